// File: rtl/display_fetch_arbiter_pkg.sv
// Shared types for the display fetch arbiter: FSM states and the read-return tag.
package display_fetch_arbiter_pkg;

    localparam int IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Travels alongside every SRAM issue so the return cycle knows where the
    // data goes: the CPU port, or a word slot in one line-buffer bank.
    typedef struct packed {
        logic             valid;
        logic             is_cpu;
        logic             bank;
        logic [IDX_W-1:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/display_fetch_arbiter_if.sv
// Bundles the timing, CPU, SRAM and line-buffer signals of the arbiter.
// The arbiter uses the master modport; its environment uses slave.
interface display_fetch_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              start_frame;
    logic              start_line;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              lb_we;
    logic              lb_bank;
    logic [7:0]        lb_waddr;
    logic [DATA_W-1:0] lb_wdata;
    logic              underrun;
    logic              underrun_clr;

    modport master (
        input  start_frame, start_line, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               mem_rdata, underrun_clr,
        output cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               lb_we, lb_bank, lb_waddr, lb_wdata, underrun
    );

    modport slave (
        output start_frame, start_line, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               mem_rdata, underrun_clr,
        input  cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               lb_we, lb_bank, lb_waddr, lb_wdata, underrun
    );

endinterface

// File: rtl/display_fetch_arbiter.sv
// Arbitrates one synchronous framebuffer SRAM between scanline prefetch into a
// ping-pong line buffer and a CPU port. Fetch owns the SRAM while a line is
// loading, except for one yield cycle every CPU_SLOT fetch issues.
module display_fetch_arbiter
    import display_fetch_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int LINE_WORDS  = 40,
    parameter int LINE_STRIDE = 40,
    parameter int FB_BASE     = 0,
    parameter int CPU_SLOT    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    display_fetch_arbiter_if.master bus
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(FB_BASE);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(LINE_STRIDE);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINE_WORDS - 1);
    localparam logic [IDX_W-1:0]  SLOT_N   = IDX_W'(CPU_SLOT);

    fetch_state_t      state_q, state_d;
    logic              bank_q, bank_d;
    logic [ADDR_W-1:0] line_addr_q, line_addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  slot_q, slot_d;
    rd_tag_t           tag_q, tag_d;
    logic              cpu_wr_q, cpu_wr_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              underrun_q, underrun_d;

    logic trig, cpu_ok, issue_cpu, issue_fetch, ret_cpu, ret_fetch;

    // Next-state, issue selection and read-return steering.
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        line_addr_d = line_addr_q;
        idx_d       = idx_q;
        slot_d      = slot_q;
        underrun_d  = underrun_q;
        issue_cpu   = 1'b0;
        issue_fetch = 1'b0;

        trig = bus.start_frame | bus.start_line;
        // The cycle after a CPU issue the request is still held but already
        // served; blocking it here prevents a second issue. Gating with rst_n
        // keeps the SRAM strobe quiet while reset is asserted.
        cpu_ok = rst_n & bus.cpu_req & ~(tag_q.valid & tag_q.is_cpu);

        case (state_q)
            IDLE: issue_cpu = cpu_ok;
            FETCH: begin
                if (SLOT_N != '0 && slot_q == SLOT_N && cpu_ok) begin
                    issue_cpu = 1'b1;
                    slot_d    = '0;
                end else begin
                    issue_fetch = 1'b1;
                    idx_d       = idx_q + 1'b1;
                    // Saturate so a request arriving late still gets the next cycle.
                    if (slot_q != SLOT_N) slot_d = slot_q + 1'b1;
                    if (idx_q == LAST_IDX) state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d     = IDLE;
                line_addr_d = line_addr_q + STRIDE;
            end
            default: state_d = IDLE;
        endcase

        // A trigger always starts a fresh line next cycle. An aborted line is
        // consumed, so the restart fetches the line after it.
        if (trig) begin
            bank_d  = ~bank_q;
            state_d = FETCH;
            idx_d   = '0;
            slot_d  = '0;
            if (bus.start_frame)     line_addr_d = BASE;
            else if (state_q != IDLE) line_addr_d = line_addr_q + STRIDE;
            else                     line_addr_d = line_addr_q;
        end

        if (trig && state_q != IDLE) underrun_d = 1'b1;
        else if (bus.underrun_clr)   underrun_d = 1'b0;

        // The tag records the bank at issue, so returns from an aborted line
        // still land in the bank they were fetched for.
        tag_d.valid  = issue_cpu | issue_fetch;
        tag_d.is_cpu = issue_cpu;
        tag_d.bank   = bank_q;
        tag_d.idx    = idx_q;
        cpu_wr_d     = issue_cpu & bus.cpu_we;

        ret_cpu     = tag_q.valid & tag_q.is_cpu;
        ret_fetch   = tag_q.valid & ~tag_q.is_cpu;
        cpu_rdata_d = (ret_cpu & ~cpu_wr_q) ? bus.mem_rdata : cpu_rdata_q;
    end

    assign bus.mem_en    = issue_cpu | issue_fetch;
    assign bus.mem_we    = issue_cpu & bus.cpu_we;
    assign bus.mem_addr  = issue_cpu   ? bus.cpu_addr :
                           issue_fetch ? line_addr_q + ADDR_W'(idx_q) : '0;
    assign bus.mem_wdata = (issue_cpu & bus.cpu_we) ? bus.cpu_wdata : '0;
    assign bus.lb_we     = ret_fetch;
    assign bus.lb_bank   = ret_fetch ? tag_q.bank : bank_q;
    assign bus.lb_waddr  = ret_fetch ? tag_q.idx : '0;
    assign bus.lb_wdata  = ret_fetch ? bus.mem_rdata : '0;
    assign bus.cpu_ack   = ret_cpu;
    assign bus.cpu_rdata = cpu_rdata_d;
    assign bus.underrun  = underrun_q;

    // State registers; reset drops any in-flight return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bank_q      <= 1'b0;
            line_addr_q <= BASE;
            idx_q       <= '0;
            slot_q      <= '0;
            tag_q       <= '0;
            cpu_wr_q    <= 1'b0;
            cpu_rdata_q <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            line_addr_q <= line_addr_d;
            idx_q       <= idx_d;
            slot_q      <= slot_d;
            tag_q       <= tag_d;
            cpu_wr_q    <= cpu_wr_d;
            cpu_rdata_q <= cpu_rdata_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_display_fetch_arbiter.sv
// Scoreboard bench: a transaction-level model predicts SRAM issues, line-buffer
// writes and CPU acks per cycle into queues; a negedge monitor pops and compares.
module tb_display_fetch_arbiter;

    localparam int LINE_WORDS  = 40;
    localparam int LINE_STRIDE = 40;
    localparam int FB_BASE     = 0;
    localparam int CPU_SLOT    = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    display_fetch_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b();

    display_fetch_arbiter #(
        .ADDR_W(16), .DATA_W(16), .LINE_WORDS(LINE_WORDS), .LINE_STRIDE(LINE_STRIDE),
        .FB_BASE(FB_BASE), .CPU_SLOT(CPU_SLOT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b)
    );

    typedef struct { int cyc; logic we; logic [15:0] addr; logic [15:0] wdata; } mem_exp_t;
    typedef struct { int cyc; logic bank; logic [7:0] idx; logic [15:0] data; } lb_exp_t;
    typedef struct { int cyc; logic [15:0] rdata; } ack_exp_t;

    mem_exp_t memq[$];
    lb_exp_t  lbq[$];
    ack_exp_t ackq[$];

    logic [15:0] sram [65536];
    logic [15:0] mmem [65536];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic exp_und = 1'b0;
    logic done = 1'b0;

    // reference model state: line in progress, words issued, yields, etc.
    int          m_phase;      // 0 idle, 1 loading a line, 2 waiting on last word
    logic        m_bank;
    logic [15:0] m_line;
    int          m_words;
    int          m_since;
    logic        m_cpu_just;
    logic [15:0] m_rd;
    logic        m_und;

    // environment state
    logic        s_en, s_we, s_ack;
    logic [15:0] s_addr, s_wd;
    int          cpu_hold;

    function automatic logic [15:0] init_word(input int i);
        return 16'((i * 40503) ^ 16'hA5C3);
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endfunction

    // Predict this cycle from the current inputs and push expected events.
    task automatic model_step();
        logic trig, was_busy, cpu_ok, do_cpu, do_fetch;
        logic [15:0] a;
        exp_und = m_und;
        if (!rst_n) begin
            m_phase = 0; m_bank = 1'b0; m_line = 16'(FB_BASE); m_words = 0; m_since = 0;
            m_cpu_just = 1'b0; m_rd = '0; m_und = 1'b0; exp_und = 1'b0;
            return;
        end
        trig     = b.start_frame | b.start_line;
        was_busy = (m_phase != 0);
        cpu_ok   = b.cpu_req && !m_cpu_just;
        do_cpu   = 1'b0;
        do_fetch = 1'b0;
        if (m_phase == 1) begin
            if (CPU_SLOT != 0 && m_since >= CPU_SLOT && cpu_ok) do_cpu = 1'b1;
            else do_fetch = 1'b1;
        end else if (m_phase == 0) begin
            do_cpu = cpu_ok;
        end
        if (do_fetch) begin
            a = m_line + 16'(m_words);
            memq.push_back('{cyc, 1'b0, a, 16'h0});
            lbq.push_back('{cyc + 1, m_bank, 8'(m_words), mmem[a]});
            m_words++;
            m_since++;
        end
        if (do_cpu) begin
            memq.push_back('{cyc, b.cpu_we, b.cpu_addr, b.cpu_wdata});
            if (b.cpu_we) mmem[b.cpu_addr] = b.cpu_wdata;
            else m_rd = mmem[b.cpu_addr];
            ackq.push_back('{cyc + 1, m_rd});
            m_since = 0;
        end
        m_cpu_just = do_cpu;
        if (trig) begin
            m_bank = ~m_bank;
            if (b.start_frame) m_line = 16'(FB_BASE);
            else if (was_busy) m_line = m_line + 16'(LINE_STRIDE);
            m_phase = 1; m_words = 0; m_since = 0;
        end else if (m_phase == 1 && m_words == LINE_WORDS) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_phase = 0;
            m_line  = m_line + 16'(LINE_STRIDE);
        end
        if (trig && was_busy) m_und = 1'b1;
        else if (b.underrun_clr) m_und = 1'b0;
    endtask

    // One clock: model this cycle, let the SRAM serve it, advance.
    task automatic tick();
        model_step();
        @(negedge clk);
        s_en = b.mem_en; s_we = b.mem_we; s_addr = b.mem_addr; s_wd = b.mem_wdata; s_ack = b.cpu_ack;
        @(posedge clk);
        #1;
        cyc++;
        if (s_en && s_we) sram[s_addr] = s_wd;
        b.mem_rdata     = (s_en && !s_we) ? sram[s_addr] : 16'($urandom);
        b.start_frame   = 1'b0;
        b.start_line    = 1'b0;
        b.underrun_clr  = 1'b0;
        if (b.cpu_req) begin
            cpu_hold++;
            if (s_ack || cpu_hold > 300) begin
                b.cpu_req = 1'b0;
                cpu_hold  = 0;
            end
        end
    endtask

    task automatic cpu_go(input logic we, input logic [15:0] a, input logic [15:0] d);
        if (!b.cpu_req) begin
            b.cpu_req = 1'b1; b.cpu_we = we; b.cpu_addr = a; b.cpu_wdata = d;
            cpu_hold = 0;
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    int mon_hold = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outs", 32'(|{b.mem_en, b.mem_we, b.mem_addr, b.mem_wdata, b.lb_we, b.lb_bank,
                                    b.lb_waddr, b.lb_wdata, b.cpu_ack, b.cpu_rdata, b.underrun}), 32'd0);
            memq.delete(); lbq.delete(); ackq.delete();
            mon_hold = 0;
        end else begin
            while (memq.size() > 0 && memq[0].cyc < cyc) begin
                chk("mem_missed", 32'(memq[0].addr), 32'hFFFF_FFFF); void'(memq.pop_front());
            end
            if (b.mem_en) begin
                if (memq.size() > 0 && memq[0].cyc == cyc) begin
                    chk("mem_we", 32'(b.mem_we), 32'(memq[0].we));
                    chk("mem_addr", 32'(b.mem_addr), 32'(memq[0].addr));
                    if (memq[0].we) chk("mem_wdata", 32'(b.mem_wdata), 32'(memq[0].wdata));
                    void'(memq.pop_front());
                end else chk("mem_unexpected", 32'(b.mem_addr), 32'hFFFF_FFFF);
            end else if (memq.size() > 0 && memq[0].cyc == cyc) begin
                chk("mem_en_missing", 32'(b.mem_en), 32'd1); void'(memq.pop_front());
            end

            while (lbq.size() > 0 && lbq[0].cyc < cyc) begin
                chk("lb_missed", 32'(lbq[0].idx), 32'hFFFF_FFFF); void'(lbq.pop_front());
            end
            if (b.lb_we) begin
                if (lbq.size() > 0 && lbq[0].cyc == cyc) begin
                    chk("lb_bank", 32'(b.lb_bank), 32'(lbq[0].bank));
                    chk("lb_waddr", 32'(b.lb_waddr), 32'(lbq[0].idx));
                    chk("lb_wdata", 32'(b.lb_wdata), 32'(lbq[0].data));
                    void'(lbq.pop_front());
                end else chk("lb_unexpected", 32'(b.lb_waddr), 32'hFFFF_FFFF);
            end else if (lbq.size() > 0 && lbq[0].cyc == cyc) begin
                chk("lb_we_missing", 32'(b.lb_we), 32'd1); void'(lbq.pop_front());
            end

            while (ackq.size() > 0 && ackq[0].cyc < cyc) begin
                chk("ack_missed", 32'(ackq[0].rdata), 32'hFFFF_FFFF); void'(ackq.pop_front());
            end
            if (b.cpu_ack) begin
                if (ackq.size() > 0 && ackq[0].cyc == cyc) begin
                    chk("cpu_rdata", 32'(b.cpu_rdata), 32'(ackq[0].rdata));
                    void'(ackq.pop_front());
                end else chk("ack_unexpected", 32'(b.cpu_ack), 32'd0);
            end else if (ackq.size() > 0 && ackq[0].cyc == cyc) begin
                chk("cpu_ack_missing", 32'(b.cpu_ack), 32'd1); void'(ackq.pop_front());
            end

            chk("underrun", 32'(b.underrun), 32'(exp_und));

            if (b.cpu_req && !b.cpu_ack) mon_hold++;
            else mon_hold = 0;
            if (mon_hold == 300) chk("cpu_timeout", 32'(mon_hold), 32'd0);
        end

        if (done) begin
            chk("memq_empty", 32'(memq.size()), 32'd0);
            chk("lbq_empty", 32'(lbq.size()), 32'd0);
            chk("ackq_empty", 32'(ackq.size()), 32'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            sram[i] = init_word(i);
            mmem[i] = init_word(i);
        end
        rst_n = 1'b0;
        b.start_frame = 1'b0; b.start_line = 1'b0; b.underrun_clr = 1'b0;
        b.cpu_req = 1'b0; b.cpu_we = 1'b0; b.cpu_addr = '0; b.cpu_wdata = '0;
        b.mem_rdata = '0;
        cpu_hold = 0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // frame start: line 0 into bank 1, then two more lines
        b.start_frame = 1'b1; tick(); repeat (50) tick();
        b.start_line  = 1'b1; tick(); repeat (50) tick();
        b.start_line  = 1'b1; tick(); repeat (50) tick();

        // CPU read in idle
        sram[16'h1234] = 16'hBEEF; mmem[16'h1234] = 16'hBEEF;
        cpu_go(1'b0, 16'h1234, 16'h0); repeat (6) tick();

        // CPU write held through a fetch: takes the yield slot after idx 7
        b.start_line = 1'b1; tick();
        cpu_go(1'b1, 16'h0100, 16'hCAFE); repeat (55) tick();

        // abort at idx 20, then clear the sticky flag
        b.start_line = 1'b1; tick(); repeat (20) tick();
        b.start_line = 1'b1; tick(); repeat (50) tick();
        b.underrun_clr = 1'b1; tick(); repeat (3) tick();

        // frame and line together, then reset mid-fetch
        b.start_frame = 1'b1; b.start_line = 1'b1; tick(); repeat (15) tick();
        rst_n = 1'b0; b.cpu_req = 1'b0; tick(); tick();
        rst_n = 1'b1; repeat (10) tick();

        // randomized triggers, gaps, CPU traffic and clears
        for (int it = 0; it < 60; it++) begin
            int r, gap;
            r = $urandom_range(0, 3);
            if (r == 0) b.start_line = 1'b1;
            else if (r == 1) b.start_frame = 1'b1;
            else if (r == 2) begin b.start_line = 1'b1; b.start_frame = 1'b1; end
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : $urandom_range(42, 70);
            for (int g = 0; g < gap; g++) begin
                if (!b.cpu_req && $urandom_range(0, 5) == 0)
                    cpu_go(1'($urandom_range(0, 1)), 16'($urandom_range(0, 511)), 16'($urandom));
                if ($urandom_range(0, 30) == 0) b.underrun_clr = 1'b1;
                tick();
            end
        end

        repeat (60) tick();
        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL no_summary cyc=%0d", cyc);
        $fatal(1, "monitor did not finish");
    end

endmodule
